// File: rtl/fb_pkg.sv
// fb_pkg: shared types and defaults for the frame buffer loader.
// Holds the loader state encoding, the default image geometry and the
// test-pattern pixel function (used only when FB_TEST_PATTERN_EN is defined).
package fb_pkg;

    localparam int FB_DATA_W = 8;
    localparam int FB_IMG_W  = 256;
    localparam int FB_IMG_H  = 256;
    localparam int FB_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2
    } fb_state_t;

    // XOR grid: pixel index against line index gives a recognisable diagonal pattern
    function automatic logic [7:0] fb_pattern(input logic [7:0] pixel, input logic [7:0] line);
        return pixel ^ line;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// fb_dpram: simple dual-port image RAM on a single clock.
// One write port, one registered read port with read-first behaviour on an
// address collision. The array itself is never reset so it maps onto block
// RAM; only the read output register clears on reset.
module fb_dpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              VGA_CLK,
    input  logic              rst_intern,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    // Write port: store a pixel whenever the loader asserts write enable
    always_ff @(posedge VGA_CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered output; the array read sees pre-write contents, giving read-first
    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/frame_buffer_loader.sv
// frame_buffer_loader: owns the grayscale image RAM feeding VGA scan-out.
// A valid/ready pixel stream framed by s_sof is written in raster order; the
// scan-out side reads RAM_ADDR = {line, pixel} with one cycle of latency.
// Optional macro FB_TEST_PATTERN_EN adds a FILL state that writes an XOR grid
// into the whole RAM on a pat_start pulse; without it pat_start is ignored.
//
//  state | meaning
//  IDLE  | waiting for a start-of-frame pixel; non-sof pixels are dropped
//  LOAD  | storing a frame at wr_addr; sof restarts the frame and flags sof_err
//  FILL  | writing the test pattern, one address per cycle (macro builds only)
module frame_buffer_loader
    import fb_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int IMG_W  = FB_IMG_W,
    parameter int IMG_H  = FB_IMG_H,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              VGA_CLK,
    input  logic              rst_intern,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DATA,
    input  logic              pat_start,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
);

    localparam int LAST_ADDR = IMG_W * IMG_H - 1;

    fb_state_t         r_state;
    fb_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic              r_s_ready;
    logic              r_frame_done;
    logic              r_sof_err;

    logic              w_xfer;
    logic              w_last;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_done_set;
    logic              w_err_set;

    assign w_xfer = s_valid & r_s_ready;
    assign w_last = (r_wr_addr == ADDR_W'(LAST_ADDR));

`ifdef FB_TEST_PATTERN_EN
    localparam int LOG_W = $clog2(IMG_W);

    logic [LOG_W-1:0]        w_pix;
    logic [ADDR_W-LOG_W-1:0] w_line;
    logic [DATA_W-1:0]       w_pattern;

    assign w_pix     = r_wr_addr[LOG_W-1:0];
    assign w_line    = r_wr_addr[ADDR_W-1:LOG_W];
    assign w_pattern = DATA_W'(fb_pattern(8'(w_pix), 8'(w_line)));
`else
    logic w_unused_pat_start;
    assign w_unused_pat_start = pat_start;
`endif

    // State, write pointer and flag registers
    always_ff @(posedge VGA_CLK or posedge rst_intern) begin
        if (rst_intern) begin
            r_state      <= IDLE;
            r_wr_addr    <= '0;
            r_s_ready    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            // ready is registered from the next state so a pat_start edge drops it immediately
            r_s_ready    <= (w_state_nxt != FILL);
            r_frame_done <= w_done_set;
            r_sof_err    <= r_sof_err | w_err_set;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
`ifdef FB_TEST_PATTERN_EN
                if (pat_start) begin
                    w_state_nxt = FILL;
                end else
`endif
                if (w_xfer && s_sof) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_xfer && !s_sof && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef FB_TEST_PATTERN_EN
            FILL: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Write port control, pointer update and flag set conditions
    always_comb begin
        w_we          = 1'b0;
        w_waddr       = r_wr_addr;
        w_wdata       = s_data;
        w_wr_addr_nxt = r_wr_addr;
        w_done_set    = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef FB_TEST_PATTERN_EN
                if (pat_start) begin
                    w_wr_addr_nxt = '0;
                end else
`endif
                if (w_xfer && s_sof) begin
                    w_we          = 1'b1;
                    w_waddr       = '0;
                    w_wr_addr_nxt = ADDR_W'(1);
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    w_we = 1'b1;
                    if (s_sof) begin
                        w_waddr       = '0;
                        w_wr_addr_nxt = ADDR_W'(1);
                        w_err_set     = 1'b1;
                    end else begin
                        w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
                        w_done_set    = w_last;
                    end
                end
            end
`ifdef FB_TEST_PATTERN_EN
            FILL: begin
                w_we          = 1'b1;
                w_wdata       = w_pattern;
                w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
                w_done_set    = w_last;
            end
`endif
            default: begin
                w_wr_addr_nxt = '0;
            end
        endcase
    end

    assign s_ready    = r_s_ready;
    assign busy       = (r_state == LOAD) || (r_state == FILL);
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;

    fb_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .VGA_CLK    (VGA_CLK),
        .rst_intern (rst_intern),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr    (RAM_ADDR),
        .o_rdata    (RAM_DATA)
    );

endmodule

// File: tb/tb_frame_buffer_loader.sv
// tb_frame_buffer_loader: directed self-checking bench for frame_buffer_loader.
// Pattern-fill scenarios are compiled in when FB_TEST_PATTERN_EN is defined.
module tb_frame_buffer_loader;

    logic        VGA_CLK;
    logic        rst_intern;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_sof;
    logic [15:0] RAM_ADDR;
    logic [7:0]  RAM_DATA;
    logic        pat_start;
    logic        busy;
    logic        frame_done;
    logic        sof_err;

    int checks;
    int errors;
    int fd_cnt;

    frame_buffer_loader dut (
        .VGA_CLK    (VGA_CLK),
        .rst_intern (rst_intern),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .RAM_ADDR   (RAM_ADDR),
        .RAM_DATA   (RAM_DATA),
        .pat_start  (pat_start),
        .busy       (busy),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    // count every frame_done pulse, sampled away from the active edge
    always @(negedge VGA_CLK) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic sof, input logic [7:0] d);
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        @(posedge VGA_CLK); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        @(posedge VGA_CLK); #1;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v);
        RAM_ADDR = a;
        @(posedge VGA_CLK); #1;
        v = RAM_DATA;
    endtask

    task automatic test_reset();
        rst_intern = 1'b1;
        #12;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
        checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL rst_sof_err got %b exp 0", sof_err); end
        checks++; if (RAM_DATA !== 8'h00) begin errors++; $display("FAIL rst_ram_data got %h exp 00", RAM_DATA); end
        #10;
        rst_intern = 1'b0;
        @(posedge VGA_CLK); #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b exp 1", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_full_frame();
        int busy_bad;
        logic [7:0] v;
        logic [7:0] e;
        logic [15:0] addrs [8];
        busy_bad = 0;
        addrs = '{16'h12AB, 16'h0000, 16'h0001, 16'h0063, 16'h0400, 16'h07FF, 16'h8000, 16'hFFFF};
        send(1'b1, 8'h00);
        for (int i = 1; i < 100; i++) begin
            send(1'b0, 8'(i));
            if (busy !== 1'b1) busy_bad++;
        end
        checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL sof_err_early got %b exp 0", sof_err); end
        send(1'b1, 8'hC3);
        checks++; if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_set got %b exp 1", sof_err); end
        for (int i = 1; i < 65536; i++) begin
            if (i < 2048 && $urandom_range(0, 1) == 1) begin
                idle();
                if (busy !== 1'b1) busy_bad++;
            end
            send(1'b0, 8'(i));
            if (i < 65535 && busy !== 1'b1) busy_bad++;
        end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse got %b exp 1", frame_done); end
        checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL frame_done_early count %0d exp 0", fd_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_end_busy got %b exp 0", busy); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_in_load low cycles %0d exp 0", busy_bad); end
        idle();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b exp 0", frame_done); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_count got %0d exp 1", fd_cnt); end
        checks++; if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_sticky got %b exp 1", sof_err); end
        for (int k = 0; k < 8; k++) begin
            rd(addrs[k], v);
            e = (addrs[k] == 16'h0000) ? 8'hC3 : addrs[k][7:0];
            checks++; if (v !== e) begin errors++; $display("FAIL frame_read @%h got %h exp %h", addrs[k], v, e); end
        end
    endtask

    task automatic test_idle_discard();
        logic [7:0] v;
        for (int i = 0; i < 5; i++) send(1'b0, 8'hEE);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_discard_busy got %b exp 0", busy); end
        send(1'b1, 8'h5A);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_sof_busy got %b exp 1", busy); end
        rd(16'h0000, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL idle_sof_mem0 got %h exp 5a", v); end
        for (int i = 1; i < 5; i++) begin
            rd(16'(i), v);
            checks++; if (v !== 8'(i)) begin errors++; $display("FAIL idle_discard_mem @%0d got %h exp %h", i, v, 8'(i)); end
        end
    endtask

    task automatic test_read_first();
        logic [7:0] v;
        for (int i = 1; i <= 256; i++) send(1'b0, 8'h11);
        send(1'b1, 8'h00);
        for (int i = 1; i < 256; i++) send(1'b0, 8'h22);
        RAM_ADDR = 16'h0100;
        send(1'b0, 8'h77);
        checks++; if (RAM_DATA !== 8'h11) begin errors++; $display("FAIL read_first_old got %h exp 11", RAM_DATA); end
        idle();
        checks++; if (RAM_DATA !== 8'h77) begin errors++; $display("FAIL read_first_new got %h exp 77", RAM_DATA); end
        rd(16'h0001, v);
        checks++; if (v !== 8'h22) begin errors++; $display("FAIL restart_write_at1 got %h exp 22", v); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_first_busy got %b exp 1", busy); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] v;
        rst_intern = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", s_ready); end
        checks++; if (sof_err !== 1'b0) begin errors++; $display("FAIL midrst_sof_err got %b exp 0", sof_err); end
        checks++; if (RAM_DATA !== 8'h00) begin errors++; $display("FAIL midrst_ram_data got %h exp 00", RAM_DATA); end
        @(posedge VGA_CLK);
        @(posedge VGA_CLK); #2;
        rst_intern = 1'b0;
        @(posedge VGA_CLK); #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_rise got %b exp 1", s_ready); end
        idle(); idle();
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL midrst_no_done got %0d exp 1", fd_cnt); end
        rd(16'h0100, v);
        checks++; if (v !== 8'h77) begin errors++; $display("FAIL midrst_kept_100 got %h exp 77", v); end
        rd(16'h0005, v);
        checks++; if (v !== 8'h22) begin errors++; $display("FAIL midrst_kept_005 got %h exp 22", v); end
        send(1'b0, 8'h99);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_discard got %b exp 0", busy); end
    endtask

`ifndef FB_TEST_PATTERN_EN
    task automatic test_pat_ignored();
        pat_start = 1'b1;
        @(posedge VGA_CLK); #1;
        pat_start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pat_ignored_busy got %b exp 0", busy); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL pat_ignored_ready got %b exp 1", s_ready); end
    endtask
`else
    task automatic test_pattern_fill();
        logic [7:0] v;
        int n;
        int fd_before;
        fd_before = fd_cnt;
        pat_start = 1'b1;
        s_valid   = 1'b1;
        s_sof     = 1'b1;
        s_data    = 8'h99;
        @(posedge VGA_CLK); #1;
        pat_start = 1'b0;
        s_valid   = 1'b0;
        s_sof     = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", s_ready); end
        n = 0;
        while (frame_done !== 1'b1 && n < 70000) begin
            @(posedge VGA_CLK); #1;
            n++;
        end
        checks++; if (n !== 65536) begin errors++; $display("FAIL fill_cycles got %0d exp 65536", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_end_busy got %b exp 0", busy); end
        idle();
        checks++; if (fd_cnt !== fd_before + 1) begin errors++; $display("FAIL fill_done_count got %0d exp %0d", fd_cnt, fd_before + 1); end
        rd(16'h0305, v);
        checks++; if (v !== 8'h06) begin errors++; $display("FAIL fill_mem_0305 got %h exp 06", v); end
        rd(16'h0000, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL fill_mem_0000 got %h exp 00", v); end
        rd(16'h12AB, v);
        checks++; if (v !== 8'hB9) begin errors++; $display("FAIL fill_mem_12ab got %h exp b9", v); end
        fd_before = fd_cnt;
        pat_start = 1'b1;
        @(posedge VGA_CLK); #1;
        pat_start = 1'b0;
        for (int i = 0; i < 100; i++) idle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill2_busy got %b exp 1", busy); end
        rst_intern = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_rst_busy got %b exp 0", busy); end
        @(posedge VGA_CLK); #2;
        rst_intern = 1'b0;
        for (int i = 0; i < 10; i++) idle();
        checks++; if (fd_cnt !== fd_before) begin errors++; $display("FAIL fill_rst_no_done got %0d exp %0d", fd_cnt, fd_before); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_rst_ready got %b exp 1", s_ready); end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        fd_cnt    = 0;
        rst_intern = 1'b1;
        s_valid   = 1'b0;
        s_sof     = 1'b0;
        s_data    = 8'h00;
        RAM_ADDR  = 16'h0000;
        pat_start = 1'b0;
        test_reset();
        test_full_frame();
        test_idle_discard();
        test_read_first();
        test_reset_mid_load();
`ifndef FB_TEST_PATTERN_EN
        test_pat_ignored();
`else
        test_pattern_fill();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
